// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID hazard controller: opcodes, mux selects, hazard state
// encoding and the register-usage helpers.
package id_hazard_ctrl_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // Forwarding source; both branch-operand muxes share one encoding.
  typedef enum logic [2:0] {
    fwd_id      = 3'd0,
    fwd_ex      = 3'd1,
    fwd_mem_alu = 3'd2,
    fwd_mem_ld  = 3'd3,
    fwd_wb_alu  = 3'd4,
    fwd_wb_ld   = 3'd5
  } fwd_src_t;

  typedef fwd_src_t forwardingmux3_sel_t;
  typedef fwd_src_t forwardingmux4_sel_t;

  typedef enum logic {
    controlmux_ctrl = 1'b0,
    controlmux_zero = 1'b1
  } controlmux_sel_t;

  typedef logic [1:0] hazard_state_t;
  localparam hazard_state_t RUN    = 2'd0;
  localparam hazard_state_t FREEZE = 2'd1;
  localparam hazard_state_t HALT   = 2'd2;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      op_jalr, op_br, op_load, op_store, op_imm, op_reg: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      op_br, op_store, op_reg: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // x0 is hardwired to zero, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd,
                                     input logic wr);
    return wr && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// Combinational forwarding priority matcher for one ID source operand
// (EX over MEM over WB; an EX load cannot forward and falls through).
module fwd_sel_unit
  import id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       ex_load_regfile,
  input  logic       mem_load_regfile,
  input  logic       wb_load_regfile,
  input  logic       ex_mem_read,
  input  logic       mem_mem_read,
  input  logic       wb_mem_read,
  output fwd_src_t   sel
);

  always_comb begin
    sel = fwd_id;
    if (reg_match(rs, ex_rd, ex_load_regfile) && !ex_mem_read)
      sel = fwd_ex;
    else if (reg_match(rs, mem_rd, mem_load_regfile))
      sel = mem_mem_read ? fwd_mem_ld : fwd_mem_alu;
    else if (reg_match(rs, wb_rd, wb_load_regfile))
      sel = wb_mem_read ? fwd_wb_ld : fwd_wb_alu;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard/sequencing controller beside ID: forwarding selects, load-use bubble,
// memory-stall freeze, flush and halt drain. Optional counters: HAZARD_PERF_CNT_EN.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int HALT_DRAIN = 3
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          id_opcode_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic [4:0]          ex_rd_i,
  input  logic [4:0]          mem_rd_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                ex_load_regfile_i,
  input  logic                mem_load_regfile_i,
  input  logic                wb_load_regfile_i,
  input  logic                ex_mem_read_i,
  input  logic                mem_mem_read_i,
  input  logic                wb_mem_read_i,
  input  logic                id_flush_i,
  input  logic                id_halt_en_i,
  input  logic                imem_stall_i,
  input  logic                dmem_stall_i,
  output forwardingmux3_sel_t forwardD_o,
  output forwardingmux4_sel_t forwardE_o,
  output controlmux_sel_t     controlmux_sel_o,
  output logic                pc_load_o,
  output logic                if_id_load_o,
  output logic                id_ex_load_o,
  output logic                ex_mem_load_o,
  output logic                mem_wb_load_o,
  output logic                if_id_flush_o,
  output logic                halted_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
`endif
);

  localparam int DRAIN_W = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(HALT_DRAIN);

  hazard_state_t      state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  fwd_src_t           fwd_rs1, fwd_rs2;
  logic               mem_stall, load_use, in_halt, halt_take, flush_now;

  fwd_sel_unit u_fwd_rs1 (
    .rs               (id_rs1_i),
    .ex_rd            (ex_rd_i),
    .mem_rd           (mem_rd_i),
    .wb_rd            (wb_rd_i),
    .ex_load_regfile  (ex_load_regfile_i),
    .mem_load_regfile (mem_load_regfile_i),
    .wb_load_regfile  (wb_load_regfile_i),
    .ex_mem_read      (ex_mem_read_i),
    .mem_mem_read     (mem_mem_read_i),
    .wb_mem_read      (wb_mem_read_i),
    .sel              (fwd_rs1)
  );

  fwd_sel_unit u_fwd_rs2 (
    .rs               (id_rs2_i),
    .ex_rd            (ex_rd_i),
    .mem_rd           (mem_rd_i),
    .wb_rd            (wb_rd_i),
    .ex_load_regfile  (ex_load_regfile_i),
    .mem_load_regfile (mem_load_regfile_i),
    .wb_load_regfile  (wb_load_regfile_i),
    .ex_mem_read      (ex_mem_read_i),
    .mem_mem_read     (mem_mem_read_i),
    .wb_mem_read      (wb_mem_read_i),
    .sel              (fwd_rs2)
  );

  assign mem_stall = imem_stall_i | dmem_stall_i;
  assign load_use  = (uses_rs1(id_opcode_i) && ex_mem_read_i &&
                      reg_match(id_rs1_i, ex_rd_i, ex_load_regfile_i)) ||
                     (uses_rs2(id_opcode_i) && ex_mem_read_i &&
                      reg_match(id_rs2_i, ex_rd_i, ex_load_regfile_i));
  assign in_halt   = (state == HALT);

  // FREEZE with both stalls low acts exactly like RUN, so both share these terms.
  assign halt_take = !in_halt && !mem_stall && !load_use && id_halt_en_i;
  assign flush_now = !in_halt && !mem_stall && !load_use && !id_halt_en_i && id_flush_i;
  assign halted_o  = in_halt && (drain_cnt == DRAIN_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, FREEZE: begin
        if (mem_stall)      state_nxt = FREEZE;
        else if (halt_take) state_nxt = HALT;
        else                state_nxt = RUN;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    forwardD_o       = fwd_rs1;
    forwardE_o       = fwd_rs2;
    controlmux_sel_o = controlmux_ctrl;
    pc_load_o        = 1'b1;
    if_id_load_o     = 1'b1;
    id_ex_load_o     = 1'b1;
    ex_mem_load_o    = 1'b1;
    mem_wb_load_o    = 1'b1;
    if_id_flush_o    = 1'b0;
    if (!rst) begin
      forwardD_o       = fwd_id;
      forwardE_o       = fwd_id;
      controlmux_sel_o = controlmux_zero;
    end else if (in_halt) begin
      pc_load_o        = 1'b0;
      if_id_load_o     = 1'b0;
      controlmux_sel_o = controlmux_zero;
      id_ex_load_o     = !mem_stall;
      ex_mem_load_o    = !mem_stall;
      mem_wb_load_o    = !mem_stall;
    end else if (mem_stall) begin
      pc_load_o        = 1'b0;
      if_id_load_o     = 1'b0;
      id_ex_load_o     = 1'b0;
      ex_mem_load_o    = 1'b0;
      mem_wb_load_o    = 1'b0;
    end else if (load_use) begin
      // Flush is held off here: the branch outcome in ID was computed from a stale operand.
      pc_load_o        = 1'b0;
      if_id_load_o     = 1'b0;
      controlmux_sel_o = controlmux_zero;
    end else begin
      if_id_flush_o    = flush_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (halt_take)
        drain_cnt <= '0;
      else if (in_halt && !mem_stall && (drain_cnt != DRAIN_MAX))
        drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic freeze_now, bubble_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign freeze_now = !in_halt && mem_stall;
  assign bubble_now = !in_halt && !mem_stall && load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      stall_cnt_o  <= sat_inc(stall_cnt_o, freeze_now);
      bubble_cnt_o <= sat_inc(bubble_cnt_o, bubble_now);
      flush_cnt_o  <= sat_inc(flush_cnt_o, flush_now);
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios followed by random
// cycles compared against a rule-level reference model.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int HD = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [6:0]          id_opcode;
  logic [4:0]          id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic                ex_load_regfile, mem_load_regfile, wb_load_regfile;
  logic                ex_mem_read, mem_mem_read, wb_mem_read;
  logic                id_flush, id_halt_en, imem_stall, dmem_stall;
  forwardingmux3_sel_t forwardD;
  forwardingmux4_sel_t forwardE;
  controlmux_sel_t     cm_sel;
  logic                pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic                if_id_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         stall_cnt, bubble_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: halted flag, drained-cycle count, event tallies.
  bit m_halt;
  int m_drain, m_stalls, m_bubbles, m_flushes;

  logic [6:0] ops [10];

  always #5 clk = ~clk;

  id_hazard_ctrl #(.HALT_DRAIN(HD)) dut (
    .clk                (clk),
    .rst                (rst),
    .id_opcode_i        (id_opcode),
    .id_rs1_i           (id_rs1),
    .id_rs2_i           (id_rs2),
    .ex_rd_i            (ex_rd),
    .mem_rd_i           (mem_rd),
    .wb_rd_i            (wb_rd),
    .ex_load_regfile_i  (ex_load_regfile),
    .mem_load_regfile_i (mem_load_regfile),
    .wb_load_regfile_i  (wb_load_regfile),
    .ex_mem_read_i      (ex_mem_read),
    .mem_mem_read_i     (mem_mem_read),
    .wb_mem_read_i      (wb_mem_read),
    .id_flush_i         (id_flush),
    .id_halt_en_i       (id_halt_en),
    .imem_stall_i       (imem_stall),
    .dmem_stall_i       (dmem_stall),
    .forwardD_o         (forwardD),
    .forwardE_o         (forwardE),
    .controlmux_sel_o   (cm_sel),
    .pc_load_o          (pc_load),
    .if_id_load_o       (if_id_load),
    .id_ex_load_o       (id_ex_load),
    .ex_mem_load_o      (ex_mem_load),
    .mem_wb_load_o      (mem_wb_load),
    .if_id_flush_o      (if_id_flush),
    .halted_o           (halted)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt),
    .bubble_cnt_o       (bubble_cnt),
    .flush_cnt_o        (flush_cnt)
`endif
  );

  function automatic bit ref_uses1(input logic [6:0] op);
    return op inside {op_jalr, op_br, op_load, op_store, op_imm, op_reg};
  endfunction

  function automatic bit ref_uses2(input logic [6:0] op);
    return op inside {op_br, op_store, op_reg};
  endfunction

  function automatic logic [2:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return fwd_id;
    if (ex_load_regfile && ex_rd == rs && !ex_mem_read) return fwd_ex;
    if (mem_load_regfile && mem_rd == rs) return mem_mem_read ? fwd_mem_ld : fwd_mem_alu;
    if (wb_load_regfile && wb_rd == rs) return wb_mem_read ? fwd_wb_ld : fwd_wb_alu;
    return fwd_id;
  endfunction

  function automatic bit ref_load_use();
    bit pending_load;
    pending_load = ex_load_regfile && ex_mem_read && ex_rd != 5'd0;
    return pending_load && ((ref_uses1(id_opcode) && id_rs1 == ex_rd) ||
                            (ref_uses2(id_opcode) && id_rs2 == ex_rd));
  endfunction

  // {fwdD, fwdE, cm_zero, pc, if_id, id_ex, ex_mem, mem_wb, flush, halted}
  function automatic logic [13:0] model_out();
    logic [2:0] fd, fe;
    logic       cz, fl, hl;
    logic [4:0] en;
    bit         stall, lu;
    stall = imem_stall || dmem_stall;
    lu    = ref_load_use();
    fd = ref_fwd(id_rs1);
    fe = ref_fwd(id_rs2);
    cz = 1'b0; fl = 1'b0; hl = 1'b0; en = 5'b11111;
    if (!rst) begin
      fd = fwd_id; fe = fwd_id; cz = 1'b1;
    end else if (m_halt) begin
      cz = 1'b1;
      en = {2'b00, {3{!stall}}};
      hl = (m_drain == HD);
    end else if (stall) begin
      en = 5'b00000;
    end else if (lu) begin
      cz = 1'b1;
      en = 5'b00111;
    end else begin
      fl = id_flush && !id_halt_en;
    end
    return {fd, fe, cz, en, fl, hl};
  endfunction

  function automatic logic [13:0] dut_out();
    return {forwardD, forwardE, cm_sel, pc_load, if_id_load, id_ex_load,
            ex_mem_load, mem_wb_load, if_id_flush, halted};
  endfunction

  task automatic model_reset();
    m_halt = 1'b0; m_drain = 0; m_stalls = 0; m_bubbles = 0; m_flushes = 0;
  endtask

  task automatic model_advance();
    bit stall, lu;
    stall = imem_stall || dmem_stall;
    lu    = ref_load_use();
    if (!rst) begin
      model_reset();
    end else if (m_halt) begin
      if (!stall && m_drain < HD) m_drain++;
    end else if (stall) begin
      m_stalls++;
    end else if (lu) begin
      m_bubbles++;
    end else if (id_halt_en) begin
      m_halt = 1'b1; m_drain = 0;
    end else if (id_flush) begin
      m_flushes++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare at the falling edge, then let the model follow the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    if (!rst) model_reset();
    check(tag, 32'(dut_out()), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 32'(m_stalls));
    check({tag, "_bubble_cnt"}, bubble_cnt, 32'(m_bubbles));
    check({tag, "_flush_cnt"}, flush_cnt, 32'(m_flushes));
`endif
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    id_opcode = op_lui; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_load_regfile = 1'b0; mem_load_regfile = 1'b0; wb_load_regfile = 1'b0;
    ex_mem_read = 1'b0; mem_mem_read = 1'b0; wb_mem_read = 1'b0;
    id_flush = 1'b0; id_halt_en = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  initial begin
    ops = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_csr};
    model_reset();
    idle();
    // Reset with a live EX match on rs1: selects must still read id.
    id_opcode = op_br; id_rs1 = 5'd9; ex_rd = 5'd9; ex_load_regfile = 1'b1;
    #2;
    check("rst_fwdD", 32'(forwardD), 32'(fwd_id));
    check("rst_cm", 32'(cm_sel), 32'(controlmux_zero));
    check("rst_loads", 32'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}), 32'h1f);
    check("rst_halted", 32'(halted), 32'd0);
    step("reset0");
    step("reset1");
    rst = 1'b1;
    idle();

    // Load-use: EX lw x5, ID beq x5,x6 with a flush request.
    id_opcode = op_br; id_rs1 = 5'd5; id_rs2 = 5'd6; id_flush = 1'b1;
    ex_rd = 5'd5; ex_load_regfile = 1'b1; ex_mem_read = 1'b1;
    #2;
    check("lu_cm", 32'(cm_sel), 32'(controlmux_zero));
    check("lu_pc", 32'(pc_load), 32'd0);
    check("lu_ifid", 32'(if_id_load), 32'd0);
    check("lu_idex", 32'(id_ex_load), 32'd1);
    check("lu_flush", 32'(if_id_flush), 32'd0);
    step("lu_c1");
    ex_rd = 5'd0; ex_load_regfile = 1'b0; ex_mem_read = 1'b0; id_flush = 1'b0;
    mem_rd = 5'd5; mem_load_regfile = 1'b1; mem_mem_read = 1'b1;
    #2;
    check("lu_c2_fwdD", 32'(forwardD), 32'(fwd_mem_ld));
    check("lu_c2_pc", 32'(pc_load), 32'd1);
    step("lu_c2");

    // EX add x7 beats MEM lw x7.
    idle();
    id_opcode = op_br; id_rs1 = 5'd7;
    ex_rd = 5'd7; ex_load_regfile = 1'b1;
    mem_rd = 5'd7; mem_load_regfile = 1'b1; mem_mem_read = 1'b1;
    #2;
    check("prio_fwdD", 32'(forwardD), 32'(fwd_ex));
    check("prio_pc", 32'(pc_load), 32'd1);
    step("prio");

    // Load to x0 in EX with ID reading x0.
    idle();
    id_opcode = op_br; ex_rd = 5'd0; ex_load_regfile = 1'b1; ex_mem_read = 1'b1;
    #2;
    check("x0_pc", 32'(pc_load), 32'd1);
    check("x0_fwdD", 32'(forwardD), 32'(fwd_id));
    step("x0");

    // dmem stall for 4 cycles while a flush is requested.
    idle();
    id_flush = 1'b1; dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("frz_loads", 32'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}), 32'd0);
      check("frz_flush", 32'(if_id_flush), 32'd0);
      step("frz");
    end
    dmem_stall = 1'b0;
    #2;
    check("frz_exit_flush", 32'(if_id_flush), 32'd1);
    check("frz_exit_pc", 32'(pc_load), 32'd1);
    step("frz_exit");

    // Halt entry, drain with one stalled cycle, then reset out of HALT.
    idle();
    id_halt_en = 1'b1;
    step("halt_entry");
    id_halt_en = 1'b0;
    #2;
    check("halt_pc", 32'(pc_load), 32'd0);
    check("halt_h1", 32'(halted), 32'd0);
    step("halt_h1");
    imem_stall = 1'b1;
    #2;
    check("halt_stall_idex", 32'(id_ex_load), 32'd0);
    step("halt_stall");
    imem_stall = 1'b0;
    step("halt_h2");
    #2;
    check("halt_h3", 32'(halted), 32'd0);
    step("halt_h3");
    #2;
    check("halt_done", 32'(halted), 32'd1);
    check("halt_done_pc", 32'(pc_load), 32'd0);
    step("halt_done");
    rst = 1'b0;
    #2;
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_pc", 32'(pc_load), 32'd1);
    step("halt_rst");
    rst = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
    // Two load-use bubbles then three frozen cycles.
    idle();
    id_opcode = op_reg; id_rs2 = 5'd3; ex_rd = 5'd3; ex_load_regfile = 1'b1; ex_mem_read = 1'b1;
    step("perf_lu1");
    step("perf_lu2");
    idle();
    dmem_stall = 1'b1;
    step("perf_frz1");
    step("perf_frz2");
    step("perf_frz3");
    dmem_stall = 1'b0;
    #2;
    check("perf_bubbles", bubble_cnt, 32'd2);
    check("perf_stalls", stall_cnt, 32'd3);
    step("perf_after");
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      id_opcode        = ops[$urandom_range(0, 9)];
      id_rs1           = 5'($urandom_range(0, 3));
      id_rs2           = 5'($urandom_range(0, 3));
      ex_rd            = 5'($urandom_range(0, 3));
      mem_rd           = 5'($urandom_range(0, 3));
      wb_rd            = 5'($urandom_range(0, 3));
      ex_load_regfile  = 1'($urandom_range(0, 1));
      mem_load_regfile = 1'($urandom_range(0, 1));
      wb_load_regfile  = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      mem_mem_read     = 1'($urandom_range(0, 1));
      wb_mem_read      = 1'($urandom_range(0, 1));
      imem_stall       = ($urandom_range(0, 9) == 0);
      dmem_stall       = ($urandom_range(0, 7) == 0);
      id_flush         = ($urandom_range(0, 3) == 0);
      id_halt_en       = ($urandom_range(0, 24) == 0);
      rst              = m_halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) != 0);
      step("rand");
    end
    rst = 1'b1;
    idle();
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core; sits beside the ID stage.
- Drives ID branch-operand forwarding selects, NOP injection (controlmux), per-register load enables and IF/ID flush.
- Sequences memory-stall freezes and the self-loop halt drain.

Parameters:
- HALT_DRAIN, 3, cycles after halt entry before halted_o asserts (EX, MEM, WB drain).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_opcode_i  in  7  rv32i_opcode of instruction in ID.
- id_rs1_i, id_rs2_i  in  5 each  source registers in ID.
- ex_rd_i, mem_rd_i, wb_rd_i  in  5 each  destination register per stage.
- ex_load_regfile_i, mem_load_regfile_i, wb_load_regfile_i  in  1 each  stage writes regfile.
- ex_mem_read_i, mem_mem_read_i, wb_mem_read_i  in  1 each  stage holds a load.
- id_flush_i  in  1  mispredict flush request from ID.
- id_halt_en_i  in  1  ID detected branch-to-self.
- imem_stall_i, dmem_stall_i  in  1 each  cache not ready.
- forwardD_o  out  forwardingmux3_sel_t  br_in1 select.
- forwardE_o  out  forwardingmux4_sel_t  br_in2 select.
- controlmux_sel_o  out  controlmux_sel_t  zero = inject NOP into ID/EX.
- pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o  out  1 each  register enables.
- if_id_flush_o  out  1  clear IF/ID.
- halted_o  out  1  pipeline drained after halt.

Behaviour:
- Uses: rs1 used by op_jalr, op_br, op_load, op_store, op_imm, op_reg; rs2 used by op_br, op_store, op_reg. Register x0 never matches.
- Forward select per operand, priority ex > mem > wb.
  - EX match, non-load: ex.
  - MEM match: mem_ld if mem_mem_read_i, else mem_alu.
  - WB match: wb_ld if wb_mem_read_i, else wb_alu.
  - Otherwise id.
- Load-use (combinational): a used rs matches ex_rd_i with ex_load_regfile_i & ex_mem_read_i.
  - Response: pc_load_o=0, if_id_load_o=0, controlmux_sel_o=zero, id_ex_load_o=1.
  - if_id_flush_o is suppressed because br_en is stale.
  - Exactly one bubble: the next cycle the load is in MEM and is forwarded as mem_ld.
- FSM states RUN, FREEZE, HALT. Reset state is RUN.
- RUN:
  - imem_stall_i|dmem_stall_i moves to FREEZE in the same cycle, combinationally: all five load enables = 0, flush = 0.
  - id_halt_en_i with no stall and no load-use moves to HALT; the drain counter loads 0.
- FREEZE:
  - All enables stay 0 while any stall is high.
  - Return to RUN on the first cycle both stalls are low; that cycle behaves as RUN, including load-use and flush.
  - id_flush_i is ignored while frozen. ID is held, so the request re-presents on exit.
- HALT:
  - pc_load_o=0, if_id_load_o=0, controlmux_sel_o=zero.
  - Downstream enables follow the memory stalls.
  - The counter increments on each unfrozen cycle and saturates at HALT_DRAIN; halted_o=1 when it equals HALT_DRAIN.
  - Exit only by reset.
- Flush: if_id_flush_o = id_flush_i in RUN, with no load-use and no mem stall.
- Simultaneous events:
  - Mem stall overrides load-use and flush.
  - Load-use overrides halt.
  - Halt and flush are mutually exclusive by ID construction; halt wins if both arrive.
- Reset values while rst low: state RUN, counters 0, halted_o=0, all load enables 1, controlmux_sel_o=zero, forward selects id, if_id_flush_o=0.
- Reset mid-FREEZE or mid-HALT returns to RUN immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o, bubble_cnt_o, flush_cnt_o, each CNT_W bits, counting FREEZE cycles, load-use bubbles and asserted flushes respectively. Counters saturate at all-ones and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- forwardingmux3, forwardingmux4 and controlmux selects stay in rv32i_mux_types.
- hazard_state_t (RUN/FREEZE/HALT) goes in rv32i_types.
- One natural sub-module, fwd_sel_unit: a combinational priority matcher instantiated twice, once per operand.

Test Plan:
- EX lw x5; ID beq x5,x6 -> cycle 1: controlmux=zero, pc/if_id load 0, flush 0; cycle 2: forwardD=mem_ld, no stall.
- EX add x7; MEM lw x7; ID bne x7 -> forwardD=ex (EX priority), no stall.
- Same rd=x0 in EX with ld -> no stall, forwardD=id.
- dmem_stall_i high 4 cycles during id_flush_i=1 -> all enables 0, flush 0 for 4 cycles; flush=1 on the 5th.
- id_halt_en_i=1 in RUN -> pc_load 0 thereafter; halted_o=1 exactly 3 unfrozen cycles later; rst low -> RUN, halted_o=0.
- With HAZARD_PERF_CNT_EN: 2 bubbles + 3 frozen cycles -> bubble_cnt_o=2, stall_cnt_o=3.
